shift_unit_mc: RTL and testbench

- Multi-cycle 32-bit shifter for the processor ALU path.
- Consumes the fixed-distance stages (sll/sra by 16, 8, 4, 2, 1). It applies one stage per cycle, selected by one shamt bit, MSB first.
- Frees the single-cycle ALU from a deep barrel-shifter path. It sits beside the multdiv unit and uses the same start/ready handshake.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/shift_stage_sel.sv | 51 +++++
 rtl/shift_unit_mc.sv | 93 +++++++++
 tb/tb_shift_unit_mc.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: shift opcodes, shifter FSM encoding and widths.
package alu_pkg;

    localparam int unsigned ALU_W   = 32;
    localparam int unsigned SHAMT_BITS = 5;
    localparam int unsigned K_W     = 3;

    localparam logic SHIFT_OP_SLL = 1'b0;
    localparam logic SHIFT_OP_SRA = 1'b1;

    localparam logic [4:0] ALU_OP_SLL = 5'b00100;
    localparam logic [4:0] ALU_OP_SRA = 5'b00101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } shift_state_e;

endpackage

// File: rtl/shift_stage_sel.sv
// One fixed-distance shift stage per cycle: picks the 2^k stage for the
// selected direction, or passes acc through when this shamt bit is clear.
module shift_stage_sel
    import alu_pkg::*;
(
    input  logic [ALU_W-1:0] acc,
    input  logic [K_W-1:0]   k,
    input  logic             op_sra,
    input  logic             en,
    output logic [ALU_W-1:0] stage_out_c
);

    logic [ALU_W-1:0] sll_16, sll_8, sll_4, sll_2, sll_1;
    logic [ALU_W-1:0] sra_16, sra_8, sra_4, sra_2, sra_1;
    logic [ALU_W-1:0] sll_sel, sra_sel;

    // Hard-wired stages; sll zero-fills, sra replicates the sign bit.
    assign sll_16 = {acc[15:0], 16'b0};
    assign sll_8  = {acc[23:0], 8'b0};
    assign sll_4  = {acc[27:0], 4'b0};
    assign sll_2  = {acc[29:0], 2'b0};
    assign sll_1  = {acc[30:0], 1'b0};
    assign sra_16 = {{16{acc[31]}}, acc[31:16]};
    assign sra_8  = {{8{acc[31]}},  acc[31:8]};
    assign sra_4  = {{4{acc[31]}},  acc[31:4]};
    assign sra_2  = {{2{acc[31]}},  acc[31:2]};
    assign sra_1  = {acc[31],       acc[31:1]};

    // Select the stage for the current counter value.
    always_comb begin
        sll_sel = acc;
        sra_sel = acc;
        case (k)
            3'd4: begin sll_sel = sll_16; sra_sel = sra_16; end
            3'd3: begin sll_sel = sll_8;  sra_sel = sra_8;  end
            3'd2: begin sll_sel = sll_4;  sra_sel = sra_4;  end
            3'd1: begin sll_sel = sll_2;  sra_sel = sra_2;  end
            3'd0: begin sll_sel = sll_1;  sra_sel = sra_1;  end
            default: begin sll_sel = acc; sra_sel = acc; end
        endcase
    end

    // Direction and enable mux.
    always_comb begin
        stage_out_c = acc;
        if (en) begin
            stage_out_c = (op_sra == SHIFT_OP_SRA) ? sra_sel : sll_sel;
        end
    end

endmodule

// File: rtl/shift_unit_mc.sv
// Multi-cycle 32-bit shifter: one power-of-two stage per cycle, MSB of
// shamt first, fixed six-cycle start-to-ready latency.
module shift_unit_mc
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ctrl_shift,
    input  logic               op_sra,
    input  logic [WIDTH-1:0]   data_operand,
    input  logic [SHAMT_W-1:0] data_shamt,
    output logic [WIDTH-1:0]   data_result,
    output logic               data_resultRDY,
    output logic               busy
);

    localparam logic [K_W-1:0] K_TOP = K_W'(SHAMT_W - 1);

    shift_state_e       state;
    logic [K_W-1:0]     k_q;
    logic [WIDTH-1:0]   acc;
    logic [SHAMT_W-1:0] shamt_q;
    logic               op_q;
    logic [WIDTH-1:0]   stage_out_c;
    logic               stage_en_c;

    assign stage_en_c = shamt_q[k_q];

    shift_stage_sel u_stage (
        .acc         (acc),
        .k           (k_q),
        .op_sra      (op_q),
        .en          (stage_en_c),
        .stage_out_c (stage_out_c)
    );

    // Control FSM, stage counter, operand latches and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= ST_IDLE;
            k_q            <= K_TOP;
            acc            <= '0;
            shamt_q        <= '0;
            op_q           <= 1'b0;
            data_result    <= '0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ctrl_shift) begin
                        acc     <= data_operand;
                        shamt_q <= data_shamt;
                        op_q    <= op_sra;
                        k_q     <= K_TOP;
                        busy    <= 1'b1;
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    acc <= stage_out_c;
                    if (k_q == '0) begin
                        data_result    <= stage_out_c;
                        data_resultRDY <= 1'b1;
                        busy           <= 1'b0;
                        state          <= ST_DONE;
                    end else begin
                        k_q <= k_q - K_W'(1);
                    end
                end
                ST_DONE: begin
                    // Result is presented this cycle; a new start may relatch now.
                    if (ctrl_shift) begin
                        acc     <= data_operand;
                        shamt_q <= data_shamt;
                        op_q    <= op_sra;
                        k_q     <= K_TOP;
                        busy    <= 1'b1;
                        state   <= ST_SHIFT;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_unit_mc.sv
// Self-checking bench for shift_unit_mc against a plain-arithmetic shift model.
module tb_shift_unit_mc;

    logic        clock;
    logic        reset;
    logic        ctrl_shift;
    logic        op_sra;
    logic [31:0] data_operand;
    logic [4:0]  data_shamt;
    logic [31:0] data_result;
    logic        data_resultRDY;
    logic        busy;

    int total = 0;
    int bad   = 0;

    shift_unit_mc #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_shift     (ctrl_shift),
        .op_sra         (op_sra),
        .data_operand   (data_operand),
        .data_shamt     (data_shamt),
        .data_result    (data_result),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] ref_shift(input logic sra, input logic [31:0] v, input int s);
        if (sra) return 32'($signed(v) >>> s);
        else     return v << s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_start(input logic sra, input logic [31:0] v, input logic [4:0] s);
        ctrl_shift   = 1'b1;
        op_sra       = sra;
        data_operand = v;
        data_shamt   = s;
    endtask

    // Wait for the ready pulse; returns cycles counted and busy-high cycles seen.
    task automatic wait_rdy(output int n, output int nbusy);
        n = 0;
        nbusy = 0;
        while (!data_resultRDY && n < 20) begin
            if (busy) nbusy++;
            tick();
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic sra, input logic [31:0] v,
                          input logic [4:0] s, input bit scramble);
        int n, nb;
        logic [31:0] exp;
        exp = ref_shift(sra, v, int'(s));
        drive_start(sra, v, s);
        tick();
        ctrl_shift = 1'b0;
        if (scramble) begin
            op_sra       = ~sra;
            data_operand = $urandom;
            data_shamt   = 5'($urandom);
        end
        wait_rdy(n, nb);
        chk({tag, " latency"}, 32'(n), 32'd5);
        chk({tag, " busy_cycles"}, 32'(nb), 32'd5);
        chk({tag, " result"}, data_result, exp);
        chk({tag, " busy_at_rdy"}, 32'(busy), 32'd0);
        tick();
        chk({tag, " rdy_one_cycle"}, 32'(data_resultRDY), 32'd0);
        chk({tag, " result_held"}, data_result, exp);
    endtask

    initial begin
        int n, nb, pulses;
        logic [31:0] e1, e2, v;
        logic        o;
        logic [4:0]  s;

        reset = 1'b1;
        ctrl_shift = 1'b0;
        op_sra = 1'b0;
        data_operand = '0;
        data_shamt = '0;
        tick();
        tick();
        chk("reset result", data_result, 32'h0);
        chk("reset rdy", 32'(data_resultRDY), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        reset = 1'b0;
        tick();

        // Directed corner cases.
        run_op("sra_f0_8",   1'b1, 32'hF000_0000, 5'd8,  1'b0);
        chk("sra_f0_8 const", data_result, 32'hFFF0_0000);
        run_op("sll_1_31",   1'b0, 32'h0000_0001, 5'd31, 1'b0);
        chk("sll_1_31 const", data_result, 32'h8000_0000);
        run_op("sll_0",      1'b0, 32'h1234_5678, 5'd0,  1'b0);
        chk("sll_0 const", data_result, 32'h1234_5678);
        run_op("sra_7f_31",  1'b1, 32'h7FFF_FFFF, 5'd31, 1'b0);
        chk("sra_7f_31 const", data_result, 32'h0000_0000);
        run_op("sra_80_31",  1'b1, 32'h8000_0000, 5'd31, 1'b0);
        chk("sra_80_31 const", data_result, 32'hFFFF_FFFF);

        // Start while busy is ignored.
        e1 = ref_shift(1'b0, 32'hA5A5_0001, 3);
        drive_start(1'b0, 32'hA5A5_0001, 5'd3);
        tick();
        ctrl_shift = 1'b0;
        tick();
        drive_start(1'b1, 32'hDEAD_BEEF, 5'd17);
        tick();
        ctrl_shift = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (data_resultRDY) begin
                pulses++;
                chk("ignore result", data_result, e1);
            end
            tick();
        end
        chk("ignore pulses", 32'(pulses), 32'd1);
        chk("ignore busy_idle", 32'(busy), 32'd0);

        // Start in the DONE cycle.
        e1 = ref_shift(1'b1, 32'h8000_0000, 1);
        e2 = ref_shift(1'b0, 32'h0000_000F, 4);
        drive_start(1'b1, 32'h8000_0000, 5'd1);
        tick();
        ctrl_shift = 1'b0;
        wait_rdy(n, nb);
        chk("b2b first latency", 32'(n), 32'd5);
        chk("b2b first result", data_result, e1);
        chk("b2b first const", data_result, 32'hC000_0000);
        drive_start(1'b0, 32'h0000_000F, 5'd4);
        tick();
        ctrl_shift = 1'b0;
        chk("b2b busy", 32'(busy), 32'd1);
        wait_rdy(n, nb);
        chk("b2b spacing", 32'(n + 1), 32'd6);
        chk("b2b second result", data_result, e2);
        chk("b2b second const", data_result, 32'h0000_00F0);
        tick();

        // Reset mid-operation with a concurrent start.
        drive_start(1'b1, 32'hFFFF_0000, 5'd4);
        tick();
        ctrl_shift = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        drive_start(1'b0, 32'h0000_0003, 5'd2);
        tick();
        reset = 1'b0;
        ctrl_shift = 1'b0;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort rdy", 32'(data_resultRDY), 32'd0);
        chk("abort result", data_result, 32'h0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (data_resultRDY) pulses++;
            tick();
        end
        chk("abort no_rdy", 32'(pulses), 32'd0);
        run_op("after_abort", 1'b1, 32'h8765_4321, 5'd12, 1'b0);

        // Randomized operations with inputs scrambled after the start edge.
        for (int i = 0; i < 40; i++) begin
            v = $urandom;
            o = 1'($urandom_range(0, 1));
            s = 5'($urandom_range(0, 31));
            run_op("rand", o, v, s, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
